// File: rtl/sd_cmd_crc_seq_if.sv
// Command-side handshake plus sd_crc_7 control/return lines for sd_cmd_crc_seq.
// ABORT/ABORTED exist only when SD_CMD_ABORT_EN is defined.
interface sd_cmd_crc_seq_if;
  logic        START;
  logic [5:0]  CMD_IDX;
  logic [31:0] CMD_ARG;
  logic        READY;
  logic        DONE;
  logic        CMD_OUT;
  logic        CMD_OE;
  logic        CRC_RST;
  logic        CRC_EN;
  logic        CRC_BITVAL;
  logic [6:0]  CRC_IN;
`ifdef SD_CMD_ABORT_EN
  logic        ABORT;
  logic        ABORTED;

  modport master (
    output START, CMD_IDX, CMD_ARG, CRC_IN, ABORT,
    input  READY, DONE, CMD_OUT, CMD_OE, CRC_RST, CRC_EN, CRC_BITVAL, ABORTED
  );
  modport slave (
    input  START, CMD_IDX, CMD_ARG, CRC_IN, ABORT,
    output READY, DONE, CMD_OUT, CMD_OE, CRC_RST, CRC_EN, CRC_BITVAL, ABORTED
  );
`else
  modport master (
    output START, CMD_IDX, CMD_ARG, CRC_IN,
    input  READY, DONE, CMD_OUT, CMD_OE, CRC_RST, CRC_EN, CRC_BITVAL
  );
  modport slave (
    input  START, CMD_IDX, CMD_ARG, CRC_IN,
    output READY, DONE, CMD_OUT, CMD_OE, CRC_RST, CRC_EN, CRC_BITVAL
  );
`endif
endinterface

// File: rtl/sd_cmd_crc_seq.sv
// SD CMD token sequencer driving an external sd_crc_7: 48-bit token, first bit 2 cycles after START,
// READY low for 1+48+GAP_CYCLES cycles; START ignored while busy. Optional SD_CMD_ABORT_EN adds ABORT/ABORTED.
module sd_cmd_crc_seq #(
  parameter int GAP_CYCLES = 8
) (
  input logic             CLK,
  input logic             RST,
  sd_cmd_crc_seq_if.slave bus
);
  localparam logic [7:0] GAP_LAST = (GAP_CYCLES < 1) ? 8'd1 : 8'(GAP_CYCLES);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, CRCS, ENDS, GAP} state_t;

  state_t      state;
  logic [39:0] frame;
  logic [5:0]  cnt;
  logic [4:0]  crc_sr;
  logic [7:0]  gap_cnt;
  logic        ready_q, done_q, out_q, oe_q, crc_rst_q, crc_en_q, bitval_q, crc_first_q;

  assign bus.READY      = ready_q;
  assign bus.DONE       = done_q;
  assign bus.CMD_OE     = oe_q;
  assign bus.CRC_RST    = crc_rst_q;
  assign bus.CRC_EN     = crc_en_q;
  assign bus.CRC_BITVAL = bitval_q;
  // The CRC unit only settles on the edge that starts the CRC phase, so its MSB goes out combinationally.
  assign bus.CMD_OUT    = crc_first_q ? bus.CRC_IN[6] : out_q;

`ifdef SD_CMD_ABORT_EN
  logic aborted_q;
  assign bus.ABORTED = aborted_q;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      frame       <= '0;
      cnt         <= '0;
      crc_sr      <= '0;
      gap_cnt     <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      out_q       <= 1'b1;
      oe_q        <= 1'b0;
      crc_rst_q   <= 1'b0;
      crc_en_q    <= 1'b0;
      bitval_q    <= 1'b0;
      crc_first_q <= 1'b0;
`ifdef SD_CMD_ABORT_EN
      aborted_q   <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
      crc_rst_q <= 1'b0;
`ifdef SD_CMD_ABORT_EN
      aborted_q <= 1'b0;
      if (bus.ABORT && (state == CLEAR || state == SHIFT || state == CRCS)) begin
        state       <= GAP;
        gap_cnt     <= 8'd1;
        oe_q        <= 1'b0;
        out_q       <= 1'b1;
        crc_en_q    <= 1'b0;
        bitval_q    <= 1'b0;
        crc_first_q <= 1'b0;
        aborted_q   <= 1'b1;
      end else
`endif
      case (state)
        IDLE: if (bus.START) begin
          frame     <= {2'b01, bus.CMD_IDX, bus.CMD_ARG};
          state     <= CLEAR;
          ready_q   <= 1'b0;
          crc_rst_q <= 1'b1;
        end
        CLEAR: begin
          state    <= SHIFT;
          cnt      <= '0;
          oe_q     <= 1'b1;
          crc_en_q <= 1'b1;
          out_q    <= frame[39];
          bitval_q <= frame[39];
          frame    <= {frame[38:0], 1'b0};
        end
        SHIFT: if (cnt == 6'd39) begin
          state       <= CRCS;
          cnt         <= '0;
          crc_en_q    <= 1'b0;
          bitval_q    <= 1'b0;
          crc_first_q <= 1'b1;
        end else begin
          cnt      <= cnt + 6'd1;
          out_q    <= frame[39];
          bitval_q <= frame[39];
          frame    <= {frame[38:0], 1'b0};
        end
        CRCS: begin
          // CRC bit 5 moves straight into out_q; crc_sr holds bits 4..0.
          if (crc_first_q) begin
            crc_first_q <= 1'b0;
            out_q       <= bus.CRC_IN[5];
            crc_sr      <= bus.CRC_IN[4:0];
          end else begin
            out_q  <= crc_sr[4];
            crc_sr <= {crc_sr[3:0], 1'b0};
          end
          if (cnt == 6'd6) begin
            state <= ENDS;
            out_q <= 1'b1;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        ENDS: begin
          state   <= GAP;
          oe_q    <= 1'b0;
          out_q   <= 1'b1;
          done_q  <= 1'b1;
          gap_cnt <= 8'd1;
        end
        GAP: if (gap_cnt >= GAP_LAST) begin
          state   <= IDLE;
          ready_q <= 1'b1;
          gap_cnt <= '0;
        end else begin
          gap_cnt <= gap_cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_cmd_crc_seq.sv
// Scoreboard bench for sd_cmd_crc_seq with a behavioural sd_crc_7 attached to the CRC lines.
module tb_sd_cmd_crc_seq;
  localparam int GAP = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   errors = 0;
  int   checks = 0;

  sd_cmd_crc_seq_if bus();
  sd_cmd_crc_seq #(.GAP_CYCLES(GAP)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  // External CRC7 unit: LFSR for x^7+x^3+1, synchronous active-high clear.
  logic [6:0] crc_unit = '0;
  always @(posedge CLK) begin
    if (bus.CRC_RST)
      crc_unit <= '0;
    else if (bus.CRC_EN)
      crc_unit <= {crc_unit[5:3], crc_unit[2] ^ (bus.CRC_BITVAL ^ crc_unit[6]),
                   crc_unit[1:0], bus.CRC_BITVAL ^ crc_unit[6]};
  end
  assign bus.CRC_IN = crc_unit;

  // Reference token: CRC7 as the remainder of frame*x^7 modulo x^7+x^3+1 by long division.
  function automatic logic [47:0] ref_token(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] f;
    logic [46:0] r;
    logic [46:0] poly;
    f    = {2'b01, idx, arg};
    r    = {f, 7'd0};
    poly = 47'h89;
    for (int i = 46; i >= 7; i--)
      if (r[i]) r = r ^ (poly << (i - 7));
    return {f, r[6:0], 1'b1};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  logic [47:0] sb_q[$];
  bit          expect_abort = 1'b0;

  initial begin : monitor
    logic [47:0] bits;
    logic [47:0] want;
    int          nbits, en_cnt, rst_cnt;
    logic        oe_prev;
    bits = '0; nbits = 0; en_cnt = 0; rst_cnt = 0; oe_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        nbits = 0; en_cnt = 0; rst_cnt = 0; oe_prev = 1'b0;
      end else begin
        if (bus.CRC_EN) en_cnt++;
        if (bus.CRC_RST) begin
          rst_cnt++;
          check("clear_oe", bus.CMD_OE, 0);
        end
        if (bus.CMD_OE) begin
          bits = {bits[46:0], bus.CMD_OUT};
          nbits++;
        end
        if (oe_prev && !bus.CMD_OE) begin
          want = '0;
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_token: got %0d-bit token, want none", nbits);
          end else begin
            want = sb_q.pop_front();
          end
          if (expect_abort) begin
            expect_abort = 1'b0;
            check("abort_no_done", bus.DONE, 0);
`ifdef SD_CMD_ABORT_EN
            check("aborted_pulse", bus.ABORTED, 1);
`endif
          end else begin
            check("token_len", nbits, 48);
            check("token", bits, want);
            check("crc_en_cycles", en_cnt, 40);
            check("crc_rst_cycles", rst_cnt, 1);
            check("done_pulse", bus.DONE, 1);
          end
          nbits = 0; en_cnt = 0; rst_cnt = 0;
        end else begin
          check("done_quiet", bus.DONE, 0);
`ifdef SD_CMD_ABORT_EN
          check("aborted_quiet", bus.ABORTED, 0);
`endif
        end
        oe_prev = bus.CMD_OE;
      end
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    while (!bus.READY && k < 300) begin
      @(negedge CLK);
      k++;
    end
    if (!bus.READY) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: READY=0 after %0d cycles, want 1", k);
    end
  endtask

  // Issues one token; with junk set, START is toggled randomly with other fields while busy.
  task automatic send(input logic [5:0] idx, input logic [31:0] arg, input logic [47:0] want, input bit junk);
    int n, first_oe;
    wait_ready();
    #1;
    bus.START = 1'b1; bus.CMD_IDX = idx; bus.CMD_ARG = arg;
    sb_q.push_back(want);
    n = 0; first_oe = 0;
    while (n < 200) begin
      @(negedge CLK);
      n++;
      if (bus.CMD_OE && first_oe == 0) first_oe = n;
      if (bus.READY) break;
      #1;
      bus.START = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      if (junk) begin
        bus.CMD_IDX = 6'($urandom);
        bus.CMD_ARG = $urandom;
      end
    end
    #1 bus.START = 1'b0;
    check("first_bit_lat", first_oe, 2);
    // n-th negedge shows the state after edge n-1 past the accepting edge.
    check("ready_lat", n - 1, 1 + 48 + GAP);
  endtask

  initial begin : stim
    logic [5:0]  idx;
    logic [31:0] arg;
    int          accepts, fall_c, clr_c, n;
    logic        oe_p;
    bus.START = 1'b0; bus.CMD_IDX = '0; bus.CMD_ARG = '0;
`ifdef SD_CMD_ABORT_EN
    bus.ABORT = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    check("rst_ready", bus.READY, 1);
    check("rst_done", bus.DONE, 0);
    check("rst_cmd_out", bus.CMD_OUT, 1);
    check("rst_cmd_oe", bus.CMD_OE, 0);
    check("rst_crc_rst", bus.CRC_RST, 0);
    check("rst_crc_en", bus.CRC_EN, 0);
    check("rst_bitval", bus.CRC_BITVAL, 0);
    #1 RST = 1'b1;

    send(6'd0, 32'h0, 48'h400000000095, 1'b0);

    // START held high: one token per READY window, CLEAR GAP+1 cycles after the END cycle.
    wait_ready();
    #1;
    bus.START = 1'b1; bus.CMD_IDX = 6'd17; bus.CMD_ARG = '0;
    sb_q.push_back(48'h510000000055);
    accepts = 1; fall_c = -1; clr_c = -1; oe_p = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge CLK);
      if (oe_p && !bus.CMD_OE && fall_c < 0) fall_c = c;
      if (bus.CRC_RST && fall_c >= 0 && clr_c < 0) clr_c = c;
      oe_p = bus.CMD_OE;
      if (bus.READY && c < 100) begin
        accepts++;
        sb_q.push_back(48'h510000000055);
      end
    end
    #1 bus.START = 1'b0;
    check("b2b_tokens", accepts, 2);
    check("b2b_clear_gap", clr_c - fall_c, GAP + 1);
    wait_ready();

    send(6'd8, 32'h000001AA, 48'h48000001AA87, 1'b0);

    for (int t = 0; t < 6; t++) begin
      idx = 6'($urandom);
      arg = $urandom;
      send(idx, arg, ref_token(idx, arg), 1'b1);
    end

    // Reset during SHIFT with counter=20.
    idx = 6'($urandom);
    arg = $urandom;
    wait_ready();
    #1;
    bus.START = 1'b1; bus.CMD_IDX = idx; bus.CMD_ARG = arg;
    sb_q.push_back(ref_token(idx, arg));
    for (int c = 1; c <= 22; c++) begin
      @(negedge CLK);
      #1 bus.START = 1'b0;
    end
    RST = 1'b0;
    #1;
    check("midrst_oe", bus.CMD_OE, 0);
    check("midrst_out", bus.CMD_OUT, 1);
    check("midrst_ready", bus.READY, 1);
    sb_q.delete();
    @(negedge CLK);
    #1 RST = 1'b1;
    send(6'd0, 32'h0, 48'h400000000095, 1'b0);

`ifdef SD_CMD_ABORT_EN
    idx = 6'($urandom);
    arg = $urandom;
    wait_ready();
    #1;
    bus.START = 1'b1; bus.CMD_IDX = idx; bus.CMD_ARG = arg;
    sb_q.push_back(ref_token(idx, arg));
    expect_abort = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      #1 bus.START = 1'b0;
    end
    bus.ABORT = 1'b1;
    @(negedge CLK);
    #1 bus.ABORT = 1'b0;
    check("abort_oe", bus.CMD_OE, 0);
    n = 13;
    while (!bus.READY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("abort_ready", n - 13, GAP);
    send(6'd17, 32'h0, 48'h510000000055, 1'b0);
`endif

    repeat (5) @(negedge CLK);
    check("sb_drain", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run did not complete, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/sd_cmd_crc_seq.md
Name: sd_cmd_crc_seq

Overview:
Sequencer for SD-bus command-token transmission that drives the external sd_crc_7 generator. It accepts a 6-bit command index plus 32-bit argument and serialises the 48-bit token MSB-first onto the CMD line. The token is start bit, transmission bit, index, argument, CRC7 and end bit. The block owns the CRC unit's clear/enable/bit inputs, captures the finished CRC7, and enforces a minimum idle gap between tokens.

Parameters:
GAP_CYCLES, 8, idle CMD-high cycles after end bit before READY reasserts (1..255)

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  asynchronous, active-low reset
START  input  1  request to send a token; accepted only when READY=1
CMD_IDX  input  6  command index, sampled on accepted START
CMD_ARG  input  32  argument, sampled on accepted START
READY  output  1  block idle and able to accept START
DONE  output  1  one-cycle pulse on the first GAP cycle after end bit
CMD_OUT  output  1  serial CMD line data
CMD_OE  output  1  CMD line output enable
CRC_RST  output  1  to sd_crc_7 RST; active-high clear, one-cycle pulse
CRC_EN  output  1  to sd_crc_7 Enable
CRC_BITVAL  output  1  to sd_crc_7 BITVAL
CRC_IN  input  7  from sd_crc_7 CRC; running CRC, updated on the edge after each enabled bit

Behaviour:
- Reset (RST=0, async): state IDLE; READY=1, DONE=0, CMD_OUT=1, CMD_OE=0, CRC_RST=0, CRC_EN=0, CRC_BITVAL=0; bit counter and gap counter cleared; CRC_RST is not asserted by reset itself.
- IDLE: READY=1. START=1 latches frame = {1'b0, 1'b1, CMD_IDX, CMD_ARG} (40 bits) and moves to CLEAR. START while READY=0 is ignored, with no queueing.
- CLEAR (1 cycle):
  - CRC_RST=1, CRC_EN=0, CMD_OE=0, CMD_OUT=1.
  - Next state SHIFT, counter=0.
- SHIFT (40 cycles):
  - CMD_OE=1; CMD_OUT=CRC_BITVAL=frame[39-counter]; CRC_EN=1.
  - Counter increments each cycle; after counter=39, go to CRC.
- CRC (7 cycles):
  - CRC_EN=0; CMD_OE=1.
  - First cycle: CMD_OUT=CRC_IN[6], and CRC_IN[5:0] is latched into a 6-bit shift register.
  - Remaining 6 cycles: CMD_OUT is taken from the shift register MSB-first.
  - CRC_IN is never sampled in later cycles.
- END (1 cycle): CMD_OE=1, CMD_OUT=1; next state GAP.
- GAP (GAP_CYCLES cycles):
  - CMD_OE=0, CMD_OUT=1.
  - DONE=1 in the first GAP cycle only.
  - Return to IDLE when the gap counter reaches GAP_CYCLES.
- Latency: the first token bit appears on CMD_OUT 2 cycles after the START edge. The token occupies exactly 48 consecutive CMD_OE=1 cycles. READY reasserts 1+48+GAP_CYCLES cycles after acceptance.
- CRC_EN is high in exactly 40 cycles per token. CRC_RST is high in exactly 1 cycle per token.
- Reset mid-token: immediate return to IDLE outputs. The next token still issues CLEAR, so stale CRC state is irrelevant.
- GAP_CYCLES=0 is illegal and is treated as 1.

Optional Feature:
SD_CMD_ABORT_EN:
- Defined:
  - Adds input ABORT (1 bit).
  - ABORT=1 in CLEAR, SHIFT or CRC means next cycle goes to GAP (CMD_OE=0, CMD_OUT=1, CRC_EN=0), skipping END.
  - DONE is not pulsed; instead ABORTED output pulses 1 cycle on entry to GAP. The full gap is still enforced.
  - ABORT in IDLE, END or GAP is ignored.
- Undefined: ABORT/ABORTED ports absent; tokens always run to completion.

Test Plan:
- CMD0: IDX=0, ARG=0x00000000 -> CMD_OUT over 48 OE cycles = 0x400000000095 (CRC7=0x4A); DONE pulses once; READY returns after 1+48+8 cycles.
- CMD17: IDX=17, ARG=0 -> 0x510000000055 (CRC7=0x2A); CRC_EN high exactly 40 cycles; CRC_RST exactly 1 cycle, in CLEAR.
- CMD8: IDX=8, ARG=0x000001AA -> 0x48000001AA87 (CRC7=0x43).
- Back-to-back: START held high continuously -> second token's CLEAR begins exactly GAP_CYCLES+1 cycles after END; START pulses while busy are ignored, exactly 2 tokens in window.
- Reset mid-SHIFT (counter=20): RST low -> CMD_OE=0, CMD_OUT=1, READY=1 asynchronously; a following CMD0 still yields 0x95 trailer.
- With SD_CMD_ABORT_EN: ABORT at SHIFT counter=10 -> CMD_OE drops next cycle, ABORTED pulses, DONE stays 0, READY after GAP_CYCLES.
